// File: rtl/data_mem_wbuf_pkg.sv
// Shared definitions for the data-memory stage with posted write buffer.
//   - CPU control bus bit positions
//   - drain FSM state encoding
//   - write-buffer entry record (addr held zero-extended to 32 bits;
//     only the low ADDR_W bits are ever non-zero)
package data_mem_wbuf_pkg;

  localparam int CTRL_MEMWR = 2;
  localparam int CTRL_MEMRD = 1;
  localparam int CTRL_REGWR = 0;

  typedef enum logic {
    DR_IDLE  = 1'b0,
    DR_WRITE = 1'b1
  } drain_st_e;

  typedef struct packed {
    logic        valid;
    logic        inflight;
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/data_mem_wbuf_if.sv
// CPU <-> data-memory bus.
//   addr/wdata/ctrl : CPU -> memory (word address, store data, {MemWr,MemRd,RegWr})
//   rdata           : memory -> CPU load data (combinational)
//   stall           : store not accepted this cycle
//   wb_count/busy   : write-buffer occupancy, RAM write in flight
interface data_mem_wbuf_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [2:0]    ctrl;
  logic [31:0]   rdata;
  logic          stall;
  logic [CW-1:0] wb_count;
  logic          busy;

  modport master (output addr, wdata, ctrl,
                  input  rdata, stall, wb_count, busy);
  modport slave  (input  addr, wdata, ctrl,
                  output rdata, stall, wb_count, busy);
endinterface

// File: rtl/data_mem_wbuf_cam.sv
// wbuf_cam: DEPTH-entry circular write buffer with parallel address match.
//   clk, rst_n            : clock, async active-low reset
//   ld_addr_i             : load address -> ld_hit_o/ld_data_o (youngest match)
//   st_addr_i/st_data_i   : store address/data -> co_hit_o (non-in-flight match)
//   push_i/coal_i         : enqueue at tail / overwrite the coalesce match
//   pop_i                 : retire head
//   mark_i                : flag the (post-pop) head as in flight
//   count_o/full_o        : occupancy
//   head_addr_o/head_data_o : head entry for the RAM write port
module wbuf_cam import data_mem_wbuf_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic [31:0]       ld_data_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  output logic              co_hit_o,
  input  logic              push_i,
  input  logic              coal_i,
  input  logic              pop_i,
  input  logic              mark_i,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [31:0]       head_data_o
);
  wbuf_entry_t [DEPTH-1:0] ent_q;
  logic [PW-1:0]           head_q, tail_q, co_idx, mark_idx;
  logic [CW-1:0]           count_q;

  // Walk oldest -> youngest so the last match seen is the youngest.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    co_hit_o  = 1'b0;
    co_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(k);
      if (ent_q[idx].valid && ent_q[idx].addr == 32'(ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = ent_q[idx].data;
      end
      if (ent_q[idx].valid && !ent_q[idx].inflight &&
          ent_q[idx].addr == 32'(st_addr_i)) begin
        co_hit_o = 1'b1;
        co_idx   = idx;
      end
    end
  end

  // On a pop the next write targets the entry behind the retiring head.
  assign mark_idx    = pop_i ? head_q + PW'(1) : head_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign head_addr_o = ent_q[head_q].addr[ADDR_W-1:0];
  assign head_data_o = ent_q[head_q].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (coal_i) ent_q[co_idx].data <= st_data_i;
      if (push_i) begin
        ent_q[tail_q] <= '{valid: 1'b1, inflight: 1'b0,
                           addr: 32'(st_addr_i), data: st_data_i};
        tail_q <= tail_q + PW'(1);
      end
      if (pop_i) begin
        ent_q[head_q].valid    <= 1'b0;
        ent_q[head_q].inflight <= 1'b0;
        head_q <= head_q + PW'(1);
      end
      // Placed last: a push into the entry that becomes head this edge
      // still ends up flagged in flight.
      if (mark_i) ent_q[mark_idx].inflight <= 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: data-memory stage behind the single-cycle CPU.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_mem_wbuf_if.slave (addr, wdata, ctrl in; rdata, stall,
//                wb_count, busy out)
// Stores are posted into wbuf_cam and drained to a word RAM whose write port
// is occupied WR_LAT cycles per write. Loads are combinational with forwarding.
module data_mem_wbuf import data_mem_wbuf_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int WR_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  data_mem_wbuf_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  // Zero at time 0 for simulation; never reset.
  logic [31:0] mem_q [2**ADDR_W] = '{default: '0};

  logic [ADDR_W-1:0] a, head_addr;
  logic [31:0]       fwd_data, head_data;
  logic              st, ld, ld_hit, co_hit, full;
  logic              push, coal, pop, mark, ram_we;
  logic [CW-1:0]     count;
  drain_st_e         state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              unused;

  assign a      = bus.addr[ADDR_W-1:0];
  assign st     = bus.ctrl[CTRL_MEMWR];
  assign ld     = bus.ctrl[CTRL_MEMRD];
  assign unused = ^{bus.addr[31:ADDR_W], bus.ctrl[CTRL_REGWR]};

  // Stall ignores a pop landing on the same edge; the CPU simply retries.
  assign coal = st & co_hit;
  assign push = st & ~co_hit & ~full;

  wbuf_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_cam (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_addr_i  (a),
    .ld_hit_o   (ld_hit),
    .ld_data_o  (fwd_data),
    .st_addr_i  (a),
    .st_data_i  (bus.wdata),
    .co_hit_o   (co_hit),
    .push_i     (push),
    .coal_i     (coal),
    .pop_i      (pop),
    .mark_i     (mark),
    .count_o    (count),
    .full_o     (full),
    .head_addr_o(head_addr),
    .head_data_o(head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mark    = 1'b0;
    pop     = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      DR_IDLE: if (count != '0) begin
        mark    = 1'b1;
        cnt_d   = LW'(WR_LAT - 1);
        state_d = DR_WRITE;
      end
      DR_WRITE: if (cnt_q == '0) begin
        pop    = 1'b1;
        ram_we = 1'b1;
        // Entries left after the pop (including one pushed this edge)
        // start immediately: no idle bubble between writes.
        if (count > CW'(1) || push) begin
          mark  = 1'b1;
          cnt_d = LW'(WR_LAT - 1);
        end else begin
          state_d = DR_IDLE;
        end
      end else begin
        cnt_d = cnt_q - LW'(1);
      end
      default: state_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[head_addr] <= head_data;
  end

  assign bus.stall    = st & ~co_hit & full;
  assign bus.wb_count = count;
  assign bus.busy     = (state_q == DR_WRITE);
  assign bus.rdata    = (!rst_n || !ld) ? 32'h0 : (ld_hit ? fwd_data : mem_q[a]);
endmodule

// File: tb/tb_data_mem_wbuf.sv
module tb_data_mem_wbuf;
  localparam int ADDR_W = 10, DEPTH = 4, WR_LAT = 3;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_wbuf_if #(.DEPTH(DEPTH)) bus();
  data_mem_wbuf #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_chk = 0, n_fail = 0;

  // Reference model: FIFO of pending stores, a busy flag with a cycle
  // countdown for the RAM port, and a plain RAM array.
  typedef struct { int addr; logic [31:0] data; bit inflight; } me_t;
  me_t         q[$];
  logic [31:0] mram [1 << ADDR_W];
  bit          m_busy;
  int          m_cnt;

  bit          cur_st, cur_ld;
  int          cur_a;
  logic [31:0] cur_d;
  logic [31:0] e_rd;
  bit          e_stall, e_busy;
  int          e_cnt;

  function automatic logic [31:0] m_rdata(bit ld, int a);
    if (!ld || !rst_n) return 32'h0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].addr == a) return q[i].data;
    return mram[a];
  endfunction

  function automatic int m_coal(int a);
    for (int i = 0; i < q.size(); i++) if (!q[i].inflight && q[i].addr == a) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int pre, ci;
    me_t e;
    if (!rst_n) return;
    pre = q.size();
    ci  = m_coal(cur_a);
    if (cur_st) begin
      if (ci >= 0) q[ci].data = cur_d;
      else if (pre < DEPTH) begin
        e.addr = cur_a; e.data = cur_d; e.inflight = 1'b0;
        q.push_back(e);
      end
    end
    if (!m_busy) begin
      if (pre > 0) begin q[0].inflight = 1'b1; m_busy = 1'b1; m_cnt = WR_LAT - 1; end
    end else if (m_cnt == 0) begin
      mram[q[0].addr] = q[0].data;
      void'(q.pop_front());
      if (q.size() > 0) begin q[0].inflight = 1'b1; m_cnt = WR_LAT - 1; end
      else m_busy = 1'b0;
    end else m_cnt--;
  endtask

  task automatic model_reset();
    q.delete(); m_busy = 1'b0; m_cnt = 0;
  endtask

  // Drive one cycle's inputs (upper address bits and ctrl[0] are noise)
  // and compute the model's expected outputs for this cycle.
  task automatic set_in(bit st, bit ld, int a, logic [31:0] d);
    logic [31:0] r;
    r = $urandom();
    cur_st = st; cur_ld = ld; cur_a = a; cur_d = d;
    bus.addr  = (r << ADDR_W) | 32'(a);
    bus.wdata = d;
    bus.ctrl  = {st, ld, 1'($urandom_range(0, 1))};
    e_rd    = m_rdata(ld, a);
    e_stall = st && (m_coal(a) < 0) && (q.size() == DEPTH);
    e_cnt   = q.size();
    e_busy  = m_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && (q.size() > 0 || m_busy); c++) begin
      set_in(0, 0, 0, 0); tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_in(1, 1, 5, 32'h1234); #1;
    n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_chk++; if (bus.wb_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.wb_count); end
    n_chk++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_busy_stall: got %b%b want 00", bus.busy, bus.stall); end
    tick();
    rst_n = 1'b1;
    set_in(0, 1, 5, 0); #1;
    n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL load5_after_reset: got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_reset_midwrite();
    set_in(1, 0, 20, 32'h5A5A5A5A); tick();
    for (int c = 0; c < 10 && !m_busy; c++) begin set_in(0, 0, 0, 0); tick(); end
    set_in(0, 0, 0, 0); tick();
    rst_n = 1'b0; model_reset();
    set_in(0, 1, 20, 0); #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midwrite_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.wb_count !== '0) begin n_fail++; $display("FAIL midwrite_count: got %0d want 0", bus.wb_count); end
    repeat (5) tick();
    rst_n = 1'b1;
    set_in(0, 1, 20, 0); #1;
    n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL midwrite_ram: got %h want 0", bus.rdata); end
    tick();
  endtask

  task automatic test_single_store();
    set_in(1, 0, 7, 32'hDEADBEEF); #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL single_stall: got %b want 0", bus.stall); end
    tick();
    for (int c = 0; c < 8; c++) begin
      set_in(0, 1, 7, 0); #1;
      n_chk++; if (bus.rdata !== e_rd || bus.wb_count !== CW'(e_cnt) || bus.busy !== e_busy) begin
        n_fail++; $display("FAIL single_cyc%0d: got rd=%h cnt=%0d busy=%b want rd=%h cnt=%0d busy=%b",
                           c, bus.rdata, bus.wb_count, bus.busy, e_rd, e_cnt, e_busy);
      end
      tick();
    end
    set_in(0, 1, 7, 0); #1;
    n_chk++; if (bus.rdata !== 32'hDEADBEEF || bus.wb_count !== '0) begin
      n_fail++; $display("FAIL single_ram: got rd=%h cnt=%0d want deadbeef/0", bus.rdata, bus.wb_count);
    end
    tick();
  endtask

  task automatic test_fill_stall();
    for (int i = 1; i <= 5; i++) begin
      int tries;
      tries = 0;
      do begin
        set_in(1, 0, i, 32'h100 + 32'(i)); #1;
        n_chk++; if (bus.stall !== e_stall || bus.wb_count !== CW'(e_cnt)) begin
          n_fail++; $display("FAIL fill_st%0d: got stall=%b cnt=%0d want stall=%b cnt=%0d",
                             i, bus.stall, bus.wb_count, e_stall, e_cnt);
        end
        if (tries == 0) begin
          n_chk++; if (bus.stall !== (i == 5)) begin
            n_fail++; $display("FAIL fill_first_try%0d: got stall=%b want %b", i, bus.stall, i == 5);
          end
        end
        tick();
        tries++;
      end while (e_stall && tries < 20);
    end
    drain();
    for (int i = 1; i <= 5; i++) begin
      set_in(0, 1, i, 0); #1;
      n_chk++; if (bus.rdata !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL fill_ram%0d: got %h want %h", i, bus.rdata, 32'h100 + 32'(i));
      end
      tick();
    end
  endtask

  task automatic test_coalesce();
    int c0;
    set_in(1, 0, 50, 32'h5050); tick();
    for (int c = 0; c < 10 && !m_busy; c++) begin set_in(0, 0, 0, 0); tick(); end
    c0 = q.size();
    set_in(1, 0, 9, 32'h11); tick();
    set_in(1, 0, 9, 32'h22); tick();
    set_in(0, 1, 9, 0); #1;
    n_chk++; if (bus.wb_count !== CW'(c0 + 1)) begin n_fail++; $display("FAIL coal_count: got %0d want %0d", bus.wb_count, c0 + 1); end
    n_chk++; if (bus.rdata !== 32'h22) begin n_fail++; $display("FAIL coal_fwd: got %h want 22", bus.rdata); end
    tick(); drain();
    set_in(0, 1, 9, 0); #1;
    n_chk++; if (bus.rdata !== 32'h22) begin n_fail++; $display("FAIL coal_ram: got %h want 22", bus.rdata); end
    tick();
  endtask

  task automatic test_inflight_nocoal();
    set_in(1, 0, 3, 32'hAA); tick();
    for (int c = 0; c < 10 && !m_busy; c++) begin set_in(0, 0, 0, 0); tick(); end
    set_in(1, 0, 3, 32'hBB); tick();
    set_in(0, 1, 3, 0); #1;
    n_chk++; if (bus.wb_count !== CW'(2)) begin n_fail++; $display("FAIL nocoal_count: got %0d want 2", bus.wb_count); end
    n_chk++; if (bus.rdata !== 32'hBB) begin n_fail++; $display("FAIL nocoal_fwd: got %h want bb", bus.rdata); end
    tick(); drain();
    set_in(0, 1, 3, 0); #1;
    n_chk++; if (bus.rdata !== 32'hBB) begin n_fail++; $display("FAIL nocoal_ram: got %h want bb", bus.rdata); end
    tick();
  endtask

  task automatic test_full_coalesce();
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 100 + i, 32'h300 + 32'(i)); tick(); end
    set_in(1, 0, 103, 32'h77); #1;
    n_chk++; if (bus.wb_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fullco_count: got %0d want %0d", bus.wb_count, DEPTH); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fullco_stall: got %b want 0", bus.stall); end
    tick();
    set_in(0, 1, 103, 0); #1;
    n_chk++; if (bus.rdata !== 32'h77) begin n_fail++; $display("FAIL fullco_fwd: got %h want 77", bus.rdata); end
    tick(); drain();
    set_in(0, 1, 103, 0); #1;
    n_chk++; if (bus.rdata !== 32'h77) begin n_fail++; $display("FAIL fullco_ram: got %h want 77", bus.rdata); end
    tick();
  endtask

  task automatic test_ld_st_same();
    set_in(1, 1, 6, 32'h66); #1;
    n_chk++; if (bus.rdata !== e_rd) begin n_fail++; $display("FAIL ldst_old: got %h want %h", bus.rdata, e_rd); end
    tick();
    set_in(0, 1, 6, 0); #1;
    n_chk++; if (bus.rdata !== 32'h66) begin n_fail++; $display("FAIL ldst_new: got %h want 66", bus.rdata); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom()); #1;
      n_chk++; if (bus.rdata !== e_rd || bus.stall !== e_stall ||
                   bus.wb_count !== CW'(e_cnt) || bus.busy !== e_busy) begin
        n_fail++; $display("FAIL rand_cyc%0d: got rd=%h st=%b cnt=%0d busy=%b want rd=%h st=%b cnt=%0d busy=%b",
                           c, bus.rdata, bus.stall, bus.wb_count, bus.busy, e_rd, e_stall, e_cnt, e_busy);
      end
      tick();
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, i, 0); #1;
      n_chk++; if (bus.rdata !== mram[i]) begin n_fail++; $display("FAIL rand_ram%0d: got %h want %h", i, bus.rdata, mram[i]); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mram[i] = 32'h0;
    model_reset();
    bus.addr = '0; bus.wdata = '0; bus.ctrl = '0;
    test_reset();
    test_reset_midwrite();
    test_single_store();
    test_fill_stall();
    test_coalesce();
    test_inflight_nocoal();
    test_full_coalesce();
    test_ld_st_same();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
